// File: rtl/sync_fifo_pkg.sv
// Shared constants for the flagged synchronous FIFO: read-mode selectors and
// the occupancy-counter width helper.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit wider than the address
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage array: synchronous write port, asynchronous read port.
// Contents are intentionally never reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered occupancy count, full/empty/almost flags,
// sticky overflow/underflow errors and selectable standard or FWFT read mode.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 6,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);

  if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_bad_params
    $error("sync_fifo_flags: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [CW-1:0]         wr_ptr_r;
  logic [CW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  ovf_r;
  logic                  udf_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  ovf_set_s;
  logic                  udf_set_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;

  // Accept/reject decisions and next occupancy
  always_comb begin
    rd_acc_s    = read_enable & ~empty_r;
    wr_acc_s    = write_enable & (~full_r | rd_acc_s);
    ovf_set_s   = write_enable & ~wr_acc_s;
    udf_set_s   = read_enable & empty_r;
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, flags (decoded from the next count so they stay aligned with fill_count) and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {CW{1'b0}};
      rd_ptr_r <= {CW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + CW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + CW'(1);
      end
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CW'(DEPTH));
      empty_r  <= (count_nxt_s == {CW{1'b0}});
      afull_r  <= (count_nxt_s >= CW'(AFULL_THRESH));
      aempty_r <= (count_nxt_s <= CW'(AEMPTY_THRESH));
      ovf_r    <= ovf_set_s | (ovf_r & ~err_clr);
      udf_r    <= udf_set_s | (udf_r & ~err_clr);
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc_s),
    .wr_addr(wr_ptr_r[ADDR_WIDTH-1:0]),
    .wr_data(data_in),
    .rd_addr(rd_ptr_r[ADDR_WIDTH-1:0]),
    .rd_data(mem_rdata_s)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = mem_rdata_s;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_r;
    // Registered read data, refreshed only on an accepted pop
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_acc_s) begin
        dout_r <= mem_rdata_s;
      end
    end
    assign data_out = dout_r;
  end

  // Pointer wrap bits only disambiguate full vs empty; occupancy is tracked separately
  logic unused_ptr_msb_s;
  assign unused_ptr_msb_s = wr_ptr_r[ADDR_WIDTH] ^ rd_ptr_r[ADDR_WIDTH];

  assign fill_count   = count_r;
  assign fifo_full    = full_r;
  assign fifo_empty   = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed table-driven bench for sync_fifo_flags (default STD instance) plus
// hand sequences for wrap-around ordering and the FWFT instance.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       rst0, we0, re0, clr0;
  logic [5:0] din0, dout0;
  logic [4:0] cnt0;
  logic       full0, empty0, afull0, aempty0, ovf0, udf0;

  // FWFT instance
  logic       rst1, we1, re1, clr1;
  logic [5:0] din1, dout1;
  logic [4:0] cnt1;
  logic       full1, empty1, afull1, aempty1, ovf1, udf1;

  sync_fifo_flags u_std (
    .clk(clk), .rst(rst0), .data_in(din0), .write_enable(we0), .read_enable(re0),
    .err_clr(clr0), .data_out(dout0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(afull0), .almost_empty(aempty0), .fill_count(cnt0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_flags #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst1), .data_in(din1), .write_enable(we1), .read_enable(re1),
    .err_clr(clr1), .data_out(dout1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(afull1), .almost_empty(aempty1), .fill_count(cnt1),
    .overflow(ovf1), .underflow(udf1)
  );

  typedef struct {
    logic       rst, we, re, clr;
    logic [5:0] din;
    int         cnt;
    logic       ovf, udf;
    int         dout;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic rd, input logic c,
                     input int d, input int cnt, input logic ovf, input logic udf, input int dout);
    vec_t v;
    v.rst = r; v.we = w; v.re = rd; v.clr = c; v.din = 6'(d);
    v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic drive0(input logic r, input logic w, input logic rd, input logic c, input logic [5:0] d);
    rst0 = r; we0 = w; re0 = rd; clr0 = c; din0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic rd, input logic c, input logic [5:0] d);
    rst1 = r; we1 = w; re1 = rd; clr1 = c; din1 = d;
  endtask

  initial begin
    logic [5:0] q[$];
    logic [5:0] d;
    logic       w, r;
    bit         fill;
    int         exp_d;

    drive0(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);

    // rst, we, re, clr, din, count, ovf, udf, dout
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(0, 1, 0, 0, i, i, 0, 0, 0);
    add(0, 1, 0, 0, 17, 16, 1, 0, 0);             // write into full
    add(0, 1, 0, 1, 18, 16, 1, 0, 0);             // clear loses to new overflow
    add(0, 0, 0, 1, 0, 16, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 16 - i, 0, 0, i);
    add(0, 0, 1, 0, 0, 0, 0, 1, 16);              // read from empty, data holds
    add(0, 0, 0, 1, 0, 0, 0, 0, 16);
    add(0, 1, 1, 0, 33, 1, 0, 1, 16);             // r+w at empty: write only
    add(0, 0, 0, 1, 0, 1, 0, 0, 16);
    for (int i = 34; i <= 37; i++) add(0, 1, 0, 0, i, i - 32, 0, 0, 16);
    add(0, 1, 1, 0, 38, 5, 0, 0, 33);             // r+w at count 5
    for (int i = 39; i <= 49; i++) add(0, 1, 0, 0, i, i - 33, 0, 0, 33);
    add(0, 1, 1, 0, 50, 16, 0, 0, 34);            // r+w at full
    add(0, 1, 0, 0, 51, 16, 1, 0, 34);
    for (int k = 0; k < 7; k++) add(0, 0, 1, 0, 0, 15 - k, 1, 0, 35 + k);
    add(1, 1, 1, 1, 5, 0, 0, 0, 0);               // reset at count 9 with overflow
    add(0, 0, 1, 0, 0, 0, 0, 1, 0);               // contents discarded
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive0(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].clr, vecs[i].din);
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), int'(cnt0), vecs[i].cnt);
      chk($sformatf("v%0d full", i), int'(full0), int'(vecs[i].cnt == 16));
      chk($sformatf("v%0d empty", i), int'(empty0), int'(vecs[i].cnt == 0));
      chk($sformatf("v%0d afull", i), int'(afull0), int'(vecs[i].cnt >= 14));
      chk($sformatf("v%0d aempty", i), int'(aempty0), int'(vecs[i].cnt <= 2));
      chk($sformatf("v%0d overflow", i), int'(ovf0), int'(vecs[i].ovf));
      chk($sformatf("v%0d underflow", i), int'(udf0), int'(vecs[i].udf));
      chk($sformatf("v%0d data_out", i), int'(dout0), vecs[i].dout);
    end

    // Wrap-around: alternate fill-biased and drain-biased phases, scoreboard the order
    for (int c = 0; c < 320; c++) begin
      fill = ((c / 40) % 2) == 0;
      w = ($urandom_range(0, 99) < (fill ? 75 : 25));
      r = ($urandom_range(0, 99) < (fill ? 25 : 75));
      if (q.size() == 0) r = 1'b0;
      if (q.size() == 16 && !r) w = 1'b0;
      d = 6'($urandom_range(0, 63));
      drive0(1'b0, w, r, 1'b0, d);
      @(posedge clk); #1;
      if (r) begin
        exp_d = int'(q.pop_front());
        chk($sformatf("wrap%0d data_out", c), int'(dout0), exp_d);
      end
      if (w) q.push_back(d);
      chk($sformatf("wrap%0d count", c), int'(cnt0), q.size());
      chk($sformatf("wrap%0d full", c), int'(full0), int'(q.size() == 16));
      chk($sformatf("wrap%0d empty", c), int'(empty0), int'(q.size() == 0));
    end
    chk("wrap overflow", int'(ovf0), 0);
    chk("wrap underflow", int'(udf0), 0);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // FWFT: head word visible without a read
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    @(posedge clk); #1;
    chk("fwft reset empty", int'(empty1), 1);
    chk("fwft reset count", int'(cnt1), 0);
    drive1(1'b0, 1'b1, 1'b0, 1'b0, 6'h2A);
    @(posedge clk); #1;
    chk("fwft first empty", int'(empty1), 0);
    chk("fwft first data", int'(dout1), 'h2A);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    @(posedge clk); #1;
    chk("fwft hold data", int'(dout1), 'h2A);
    drive1(1'b0, 1'b1, 1'b0, 1'b0, 6'h15);
    @(posedge clk); #1;
    chk("fwft second head", int'(dout1), 'h2A);
    chk("fwft second count", int'(cnt1), 2);
    drive1(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    @(posedge clk); #1;
    chk("fwft pop1 data", int'(dout1), 'h15);
    chk("fwft pop1 count", int'(cnt1), 1);
    @(posedge clk); #1;
    chk("fwft pop2 empty", int'(empty1), 1);
    chk("fwft pop2 underflow", int'(udf1), 0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, pointer width; DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter AFULL_THRESH, default DEPTH-2, the almost_full threshold in words.
REQ-004 The block SHALL have parameter AEMPTY_THRESH, default 2, the almost_empty threshold in words.
REQ-005 The block SHALL have parameter FWFT, default 0, where 0 selects standard read mode and 1 selects first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits, the write data.
REQ-009 The block SHALL have port write_enable, input, 1 bit, the write request.
REQ-010 The block SHALL have port read_enable, input, 1 bit, the read or pop request.
REQ-011 The block SHALL have port err_clr, input, 1 bit, which clears the sticky error flags.
REQ-012 The block SHALL have port data_out, output, DATA_WIDTH bits, the read data.
REQ-013 The block SHALL have outputs fifo_full, fifo_empty, almost_full and almost_empty, each 1 bit, carrying the occupancy flags.
REQ-014 The block SHALL have output fill_count, ADDR_WIDTH+1 bits, the current occupancy, ranging 0..DEPTH.
REQ-015 The block SHALL have outputs overflow and underflow, each 1 bit, carrying the sticky error flags.

Function
REQ-016 Write is accepted iff write_enable=1 and (fifo_full=0 or a read is accepted in the same cycle); an accepted write stores data_in at wr_ptr and advances wr_ptr.
REQ-017 Read is accepted iff read_enable=1 and fifo_empty=0; no write-bypass when empty.
REQ-018 Pointers SHALL be ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH, with the memory index being the low ADDR_WIDTH bits.
REQ-019 fill_count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-020 Flags SHALL be decoded from registered fill_count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_THRESH), almost_empty = (count<=AEMPTY_THRESH).
REQ-021 With FWFT=0, data_out SHALL be registered and update on the edge that accepts a read, holding its value otherwise; read latency is 1 cycle.
REQ-022 With FWFT=1, data_out SHALL continuously show mem[rd_ptr]; the head word is valid whenever fifo_empty=0, i.e. 1 cycle after the first write into an empty FIFO, and read_enable pops it.
REQ-023 overflow SHALL set on a cycle with write_enable=1 and the write rejected.
REQ-024 underflow SHALL set on a cycle with read_enable=1 and fifo_empty=1.
REQ-025 err_clr SHALL clear overflow and underflow; a set condition in the same cycle wins.
REQ-026 A rejected access SHALL change no pointer, count or memory word.
REQ-027 Parameters violating AEMPTY_THRESH < AFULL_THRESH <= DEPTH SHALL cause an elaboration-time error.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL drive wr_ptr=rd_ptr=0, fill_count=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, overflow=underflow=0, and data_out=0 when FWFT=0.
REQ-029 rst SHALL dominate write_enable, read_enable and err_clr, and reset mid-operation SHALL discard contents.
REQ-030 Memory contents SHALL not be reset.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold the mode constants FIFO_STD=0 and FIFO_FWFT=1 and a count-width helper function.
REQ-032 Storage SHALL be sub-module fifo_mem, a DEPTH x DATA_WIDTH array with a synchronous write port and an asynchronous read port; all control logic stays in sync_fifo_flags.

Verification
REQ-033 Defaults, FWFT=0: write 16 words 1..16 -> fifo_full=1 after 16th edge, almost_full=1 from count 14, fill_count=16; 17th write -> overflow=1, contents unchanged.
REQ-034 From full: read 16 -> data_out = 1..16 in order, each 1 cycle after its read edge; fifo_empty=1 after last; extra read -> underflow=1, data_out holds 16.
REQ-035 Simultaneous read+write at count 16 and at count 5 -> both accepted, fill_count unchanged; at count 0 -> write only, underflow=1.
REQ-036 Wrap: 40 interleaved write/read pairs at random occupancy 0..16 -> scoreboard order matches and no flag error.
REQ-037 FWFT=1: write 0x2A into empty -> next cycle fifo_empty=0, data_out=0x2A without read; pop -> fifo_empty=1.
REQ-038 rst=1 at count 9 with overflow=1 -> next cycle all REQ-028 values; err_clr with a concurrent overflow -> overflow stays 1.
